// File: rtl/global_avg_broadcast.sv
// rtl/global_avg_broadcast.sv - broadcast one 7-channel vector over an IMG_WIDTH x IMG_HEIGHT pixel stream
//
// Takes one 7-channel vector per frame and emits IMG_WIDTH*IMG_HEIGHT beats that all carry it.
// A one-entry pending buffer holds the next vector, so back-to-back frames run without a gap.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   Data_In    input vector (channel 1 in the LSBs, channel 7 in the MSBs)
//   Valid_In   Data_In is valid
//   Ready_Out  block can take Data_In this cycle
//   Data_Out   broadcast pixel, same packing as Data_In
//   Valid_Out  Data_Out is valid
//   Ready_In   downstream takes Data_Out this cycle
//   SOF        beat is pixel (0,0)
//   EOL        beat is the last pixel of a row
//   EOF        beat is the last pixel of the frame

module global_avg_broadcast #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDHT*7-1:0] Data_In,
  input  logic                    Valid_In,
  output logic                    Ready_Out,
  output logic [DATA_WIDHT*7-1:0] Data_Out,
  output logic                    Valid_Out,
  input  logic                    Ready_In,
  output logic                    SOF,
  output logic                    EOL,
  output logic                    EOF
);

  localparam int VW = DATA_WIDHT * 7;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [VW-1:0] hold, pend;
  logic          pend_full;

  logic in_acc, out_acc, at_eol, at_eof;

  // Ready depends only on registered state; the rst term keeps it low while reset is held.
  assign Ready_Out = rst & ~pend_full;
  assign in_acc    = Valid_In & Ready_Out;
  assign out_acc   = Valid_Out & Ready_In;
  assign at_eol    = (col == COL_LAST);
  assign at_eof    = at_eol & (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    Valid_Out = 1'b0;
    Data_Out  = '0;
    SOF       = 1'b0;
    EOL       = 1'b0;
    EOF       = 1'b0;
    case (state)
      IDLE: begin
        if (in_acc) state_n = STREAM;
      end
      STREAM: begin
        Valid_Out = 1'b1;
        Data_Out  = hold;
        SOF       = (col == '0) && (row == '0);
        EOL       = at_eol;
        EOF       = at_eof;
        // Drop to IDLE only when the frame ends with nothing queued or arriving.
        if (out_acc && at_eof && !pend_full && !in_acc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_acc) begin
            hold <= Data_In;
            col  <= '0;
            row  <= '0;
          end
        end
        STREAM: begin
          if (out_acc) begin
            if (at_eof) begin
              col <= '0;
              row <= '0;
              // Next frame starts immediately from the pending slot, or straight from
              // the input when it arrives on the EOF cycle with the slot empty.
              if (pend_full) begin
                hold      <= pend;
                pend_full <= 1'b0;
              end else if (in_acc) begin
                hold <= Data_In;
              end
            end else if (at_eol) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
          if (in_acc && !(out_acc && at_eof)) begin
            pend      <= Data_In;
            pend_full <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_global_avg_broadcast.sv
// tb/tb_global_avg_broadcast.sv - scoreboard bench for global_avg_broadcast
module tb_global_avg_broadcast;

  localparam int DW = 32;
  localparam int VW = DW * 7;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [VW-1:0] d_in, d_out;
  logic          v_in, r_out, v_out, r_in, sof, eol, eof;

  logic [VW-1:0] d2_in, d2_out;
  logic          v2_in, r2_out, v2_out, r2_in, sof2, eol2, eof2;

  global_avg_broadcast #(.DATA_WIDHT(DW), .IMG_WIDTH(3), .IMG_HEIGHT(2)) dut (
    .clk(clk), .rst(rst), .Data_In(d_in), .Valid_In(v_in), .Ready_Out(r_out),
    .Data_Out(d_out), .Valid_Out(v_out), .Ready_In(r_in), .SOF(sof), .EOL(eol), .EOF(eof)
  );

  global_avg_broadcast #(.DATA_WIDHT(DW)) dut_big (
    .clk(clk), .rst(rst), .Data_In(d2_in), .Valid_In(v2_in), .Ready_Out(r2_out),
    .Data_Out(d2_out), .Valid_Out(v2_out), .Ready_In(r2_in), .SOF(sof2), .EOL(eol2), .EOF(eof2)
  );

  int total = 0;
  int passed = 0;
  int fails = 0;
  int beats = 0;
  bit last_acc = 1'b0;
  logic [VW+2:0] exp_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected beats of one 3x2 frame, raster order: {data, SOF, EOL, EOF}.
  task automatic push_frame(input logic [VW-1:0] v);
    logic s, e, f;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = (r == 0) && (c == 0);
        e = (c == 2);
        f = (c == 2) && (r == 1);
        exp_q.push_back({v, s, e, f});
      end
    end
  endtask

  // One clock: sample on the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [VW+2:0] e;
    @(negedge clk);
    last_acc = 1'b0;
    if (v_out && r_in) begin
      chk("sb_nonempty", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 256'({d_out, sof, eol, eof}), 256'(e));
      end
      beats++;
    end else if (v_out && exp_q.size() != 0) begin
      e = exp_q[0];
      chk("stall_hold", 256'({d_out, sof, eol, eof}), 256'(e));
    end
    if (v_in && r_out) begin
      push_frame(d_in);
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
  endtask

  logic [VW-1:0] vec_a, vec_b, vec_c, vec_x;
  int n, c_at, bb, b_sof, b_eol, b_eof, b_eof_idx, b_bad;

  initial begin
    vec_a = {32'h40E00000, 32'h40C00000, 32'h40A00000, 32'h40800000,
             32'h40400000, 32'h40000000, 32'h3F800000};
    vec_b = {7{32'hBF000000}} ^ {7{$urandom()}};
    vec_c = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             32'h55555555, 32'h66666666, 32'h77777777};
    vec_x = {32'hC1200000, 32'h41200000, 32'h3E800000, 32'h00000000,
             32'h7F800000, 32'h80000000, 32'h3DCCCCCD};

    rst = 1'b0; v_in = 1'b0; r_in = 1'b1; d_in = '0;
    v2_in = 1'b0; r2_in = 1'b1; d2_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 256'(v_out), 256'(0));
    chk("rst_ready", 256'(r_out), 256'(0));
    chk("rst_data", 256'(d_out), 256'(0));
    chk("rst_flags", 256'({sof, eol, eof}), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ready_after_rst", 256'(r_out), 256'(1));
    @(posedge clk); #1;

    // 1: single vector
    beats = 0;
    d_in = vec_a; v_in = 1'b1;
    tick();
    v_in = 1'b0;
    chk("t1_latency", 256'(v_out), 256'(1));
    chk("t1_sof_first", 256'(sof), 256'(1));
    drain(20);
    chk("t1_drained", 256'(exp_q.size()), 256'(0));
    chk("t1_beats", 256'(beats), 256'(6));
    chk("t1_idle_after", 256'(v_out), 256'(0));

    // 2: back-to-back frames, no bubble
    beats = 0;
    d_in = vec_a; v_in = 1'b1;
    tick();
    d_in = vec_b;
    tick();
    v_in = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 5) chk("t2_ready_low", 256'(r_out), 256'(0));
      chk("t2_contig", 256'(v_out), 256'(1));
      tick();
      if (k == 5) chk("t2_ready_high", 256'(r_out), 256'(1));
    end
    chk("t2_drained", 256'(exp_q.size()), 256'(0));
    chk("t2_beats", 256'(beats), 256'(12));
    chk("t2_idle_after", 256'(v_out), 256'(0));

    // 3: output stalls
    beats = 0;
    d_in = vec_c; v_in = 1'b1;
    tick();
    v_in = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      r_in = (i % 3 == 0);
      tick();
      n = i + 1;
    end
    r_in = 1'b1;
    chk("t3_drained", 256'(exp_q.size()), 256'(0));
    chk("t3_beats", 256'(beats), 256'(6));
    chk("t3_cycles", 256'(n), 256'(16));
    chk("t3_idle_after", 256'(v_out), 256'(0));

    // 4: third vector waits for the pending slot
    beats = 0;
    d_in = vec_a; v_in = 1'b1;
    tick();
    d_in = vec_b;
    tick();
    d_in = vec_c;
    c_at = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (last_acc && c_at == 0) begin
        c_at = k;
        v_in = 1'b0;
      end
      if (c_at != 0 && exp_q.size() == 0) break;
    end
    v_in = 1'b0;
    chk("t4_c_accept_cycle", 256'(c_at), 256'(6));
    chk("t4_drained", 256'(exp_q.size()), 256'(0));
    chk("t4_beats", 256'(beats), 256'(18));

    // 5: reset mid-frame with a pending vector
    d_in = vec_a; v_in = 1'b1;
    tick();
    d_in = vec_b;
    tick();
    v_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t5_async_valid", 256'(v_out), 256'(0));
    chk("t5_async_ready", 256'(r_out), 256'(0));
    chk("t5_async_data", 256'(d_out), 256'(0));
    chk("t5_async_flags", 256'({sof, eol, eof}), 256'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_ready_after", 256'(r_out), 256'(1));
    beats = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_no_b", 256'(beats), 256'(0));
    chk("t5_idle", 256'(v_out), 256'(0));

    // 6: default 44x44 geometry
    chk("t6_ready", 256'(r2_out), 256'(1));
    d2_in = vec_x; v2_in = 1'b1;
    @(posedge clk); #1;
    v2_in = 1'b0;
    bb = 0; b_sof = 0; b_eol = 0; b_eof = 0; b_eof_idx = -1; b_bad = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (v2_out && r2_in) begin
        if (d2_out !== vec_x) b_bad++;
        if (sof2) b_sof++;
        if (eol2) b_eol++;
        if (eof2) begin
          b_eof++;
          b_eof_idx = bb;
        end
        bb++;
      end
    end
    chk("t6_beats", 256'(bb), 256'(1936));
    chk("t6_eol_count", 256'(b_eol), 256'(44));
    chk("t6_sof_count", 256'(b_sof), 256'(1));
    chk("t6_eof_count", 256'(b_eof), 256'(1));
    chk("t6_eof_last", 256'(b_eof_idx), 256'(1935));
    chk("t6_data_errors", 256'(b_bad), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
